sm_mul_add: RTL and testbench

- Sequential reconstruction unit for the calculator datapath. It computes numerator = quotient × denominator + remainder on signed-magnitude operands.
- It is the inverse direction of the remainder/divide path and is used to check and rebuild division results.
- Multiplication is shift-add, one magnitude bit per clock, under a start/busy/done handshake.
- It also flags divide-by-zero and an out-of-range remainder.

---
 rtl/sm_mul_add.sv | 158 +++++++++++++++
 tb/tb_sm_mul_add.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sm_mul_add.sv
// Signed-magnitude reconstruction: numerator = quotient * denominator + remainder,
// shift-add multiply one magnitude bit per clock under a start/busy/done handshake.
module sm_mul_add #(
   parameter int MAG_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [MAG_W:0]     quotient,
   input  logic [MAG_W:0]     denominator,
   input  logic [MAG_W:0]     remainder,
   output logic               busy,
   output logic               done,
   output logic [2*MAG_W:0]   numerator,
   output logic               divbyzero,
   output logic               rem_invalid,
   output logic               zero
);

   localparam int PW    = 2 * MAG_W;
   localparam int CNT_W = $clog2(MAG_W + 1);

   typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

   state_t             state_q, state_d;
   logic [MAG_W-1:0]   q_mag_q, q_mag_d;
   logic [PW-1:0]      d_mag_q, d_mag_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               q_sign_q, q_sign_d;
   logic               d_sign_q, d_sign_d;
   logic               r_sign_q, r_sign_d;
   logic [MAG_W-1:0]   r_mag_q, r_mag_d;
   logic               dz_p_q, dz_p_d;
   logic               ri_p_q, ri_p_d;
   logic [PW:0]        num_q, num_d;
   logic               zero_q, zero_d;
   logic               dz_q, dz_d;
   logic               ri_q, ri_d;

   logic               ps;
   logic [PW-1:0]      rm_ext;
   logic [PW-1:0]      res_mag;
   logic               res_sign;

   // Signed-magnitude add of product and remainder; zero magnitude is never negative.
   always_comb begin
      ps     = q_sign_q ^ d_sign_q;
      rm_ext = {{MAG_W{1'b0}}, r_mag_q};
      if (ps == r_sign_q) begin
         res_mag  = acc_q + rm_ext;
         res_sign = ps;
      end else if (acc_q >= rm_ext) begin
         res_mag  = acc_q - rm_ext;
         res_sign = ps;
      end else begin
         res_mag  = rm_ext - acc_q;
         res_sign = r_sign_q;
      end
      if (res_mag == '0) res_sign = 1'b0;
   end

   always_comb begin
      state_d  = state_q;
      q_mag_d  = q_mag_q;
      d_mag_d  = d_mag_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      q_sign_d = q_sign_q;
      d_sign_d = d_sign_q;
      r_sign_d = r_sign_q;
      r_mag_d  = r_mag_q;
      dz_p_d   = dz_p_q;
      ri_p_d   = ri_p_q;
      num_d    = num_q;
      zero_d   = zero_q;
      dz_d     = dz_q;
      ri_d     = ri_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               q_mag_d  = quotient[MAG_W-1:0];
               d_mag_d  = {{MAG_W{1'b0}}, denominator[MAG_W-1:0]};
               acc_d    = '0;
               cnt_d    = CNT_W'(MAG_W);
               q_sign_d = quotient[MAG_W];
               d_sign_d = denominator[MAG_W];
               r_sign_d = remainder[MAG_W];
               r_mag_d  = remainder[MAG_W-1:0];
               // Flags are judged on the captured magnitudes, before the divisor gets shifted.
               dz_p_d   = (denominator[MAG_W-1:0] == '0);
               ri_p_d   = (remainder[MAG_W-1:0] >= denominator[MAG_W-1:0]);
               state_d  = MUL;
            end
         end
         MUL: begin
            if (q_mag_q[0]) acc_d = acc_q + d_mag_q;
            q_mag_d = q_mag_q >> 1;
            d_mag_d = d_mag_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ADD;
         end
         ADD: begin
            num_d   = {res_sign, res_mag};
            zero_d  = (res_mag == '0);
            dz_d    = dz_p_q;
            ri_d    = ri_p_q;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         q_mag_q  <= '0;
         d_mag_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         q_sign_q <= 1'b0;
         d_sign_q <= 1'b0;
         r_sign_q <= 1'b0;
         r_mag_q  <= '0;
         dz_p_q   <= 1'b0;
         ri_p_q   <= 1'b0;
         num_q    <= '0;
         zero_q   <= 1'b0;
         dz_q     <= 1'b0;
         ri_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_mag_q  <= q_mag_d;
         d_mag_q  <= d_mag_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         q_sign_q <= q_sign_d;
         d_sign_q <= d_sign_d;
         r_sign_q <= r_sign_d;
         r_mag_q  <= r_mag_d;
         dz_p_q   <= dz_p_d;
         ri_p_q   <= ri_p_d;
         num_q    <= num_d;
         zero_q   <= zero_d;
         dz_q     <= dz_d;
         ri_q     <= ri_d;
      end
   end

   assign busy        = (state_q == MUL) || (state_q == ADD);
   assign done        = (state_q == DONE);
   assign numerator   = num_q;
   assign divbyzero   = dz_q;
   assign rem_invalid = ri_q;
   assign zero        = zero_q;

endmodule

// File: tb/tb_sm_mul_add.sv
// Bench for sm_mul_add: directed plan vectors, reset abort, start re-pulse,
// back-to-back and random operands against an integer-arithmetic model.
module tb_sm_mul_add;

   localparam int MAG_W = 2;
   localparam int OP_W  = MAG_W + 1;
   localparam int RES_W = 2 * MAG_W + 1;
   localparam int EXP_W = RES_W + 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [OP_W-1:0]  quotient = '0;
   logic [OP_W-1:0]  denominator = '0;
   logic [OP_W-1:0]  remainder = '0;
   logic             busy, done, divbyzero, rem_invalid, zero;
   logic [RES_W-1:0] numerator;

   int               n_tests = 0;
   int               n_fail = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [RES_W-1:0] last_num = '0;
   bit               seen;

   always #5 clk = ~clk;

   sm_mul_add #(.MAG_W(MAG_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .quotient    (quotient),
      .denominator (denominator),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .numerator   (numerator),
      .divbyzero   (divbyzero),
      .rem_invalid (rem_invalid),
      .zero        (zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: signed integers, plain multiply/add, then back to signed-magnitude.
   function automatic logic [EXP_W-1:0] model(input logic [OP_W-1:0] q, d, r);
      int qv, dv, rv, res, mag;
      logic [RES_W-1:0] num;
      qv = int'(q[MAG_W-1:0]); if (q[MAG_W]) qv = -qv;
      dv = int'(d[MAG_W-1:0]); if (d[MAG_W]) dv = -dv;
      rv = int'(r[MAG_W-1:0]); if (r[MAG_W]) rv = -rv;
      res = qv * dv + rv;
      mag = (res < 0) ? -res : res;
      num = {(res < 0), mag[RES_W-2:0]};
      return {(res == 0), (d[MAG_W-1:0] == '0), (r[MAG_W-1:0] >= d[MAG_W-1:0]), num};
   endfunction

   task automatic run_op(input logic [OP_W-1:0] q, d, r, input bit repulse);
      logic [EXP_W-1:0] e;
      bit got;
      @(negedge clk);
      quotient = q; denominator = d; remainder = r; start = 1'b1;
      exp_q.push_back(model(q, d, r));
      @(posedge clk);
      got = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start       = repulse;
            quotient    = OP_W'($urandom_range(0, (1 << OP_W) - 1));
            denominator = OP_W'($urandom_range(0, (1 << OP_W) - 1));
            remainder   = OP_W'($urandom_range(0, (1 << OP_W) - 1));
            check("busy_mul", busy, 1);
         end else begin
            start = 1'b0;
         end
         if (i == MAG_W + 1) check("hold_num", numerator, last_num);
         if (done) begin
            got = 1'b1;
            check("latency", i, MAG_W + 2);
            check("busy_done", busy, 0);
            e = exp_q.pop_front();
            check("numerator", numerator, e[RES_W-1:0]);
            check("rem_invalid", rem_invalid, e[RES_W]);
            check("divbyzero", divbyzero, e[RES_W+1]);
            check("zero", zero, e[RES_W+2]);
            last_num = e[RES_W-1:0];
         end
      end
      if (!got) begin
         check("timeout", 0, 1);
         start = 1'b0;
         exp_q.delete();
      end
   endtask

   task automatic watch_idle(input int n);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("no_activity", seen, 0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_num"}, numerator, 0);
      check({tag, "_dz"}, divbyzero, 0);
      check({tag, "_ri"}, rem_invalid, 0);
      check({tag, "_zero"}, zero, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_cleared("reset");
      watch_idle(3);
      check_cleared("idle");

      // Directed plan vectors
      run_op(3'b011, 3'b110, 3'b001, 1'b0);
      check("plan1_num", numerator, 5'b10101);
      run_op(3'b111, 3'b011, 3'b111, 1'b0);
      check("plan2_num", numerator, 5'b11100);
      check("plan2_ri", rem_invalid, 1);
      run_op(3'b000, 3'b011, 3'b100, 1'b0);
      check("plan3_num", numerator, 5'b00000);
      check("plan3_zero", zero, 1);
      run_op(3'b010, 3'b000, 3'b101, 1'b0);
      check("plan4_num", numerator, 5'b10001);
      check("plan4_dz", divbyzero, 1);

      // Start re-pulsed during MUL must not launch a second operation
      run_op(3'b111, 3'b110, 3'b010, 1'b1);
      watch_idle(6);

      // Reset during ADD aborts without a done pulse
      @(negedge clk);
      quotient = 3'b011; denominator = 3'b011; remainder = 3'b001; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_cleared("abort");
      last_num = '0;
      watch_idle(6);
      run_op(3'b010, 3'b011, 3'b010, 1'b0);
      check("plan5_num", numerator, 5'b01000);

      // Back-to-back: second start in the IDLE cycle right after DONE
      run_op(3'b101, 3'b111, 3'b110, 1'b0);
      run_op(3'b011, 3'b011, 3'b000, 1'b0);

      // Random operands
      repeat (24) begin
         run_op(OP_W'($urandom_range(0, (1 << OP_W) - 1)),
                OP_W'($urandom_range(0, (1 << OP_W) - 1)),
                OP_W'($urandom_range(0, (1 << OP_W) - 1)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
